divisor: RTL and testbench
==========================

// Module: divisor
// PURPOSE
//  - Unsigned 4-bit / 4-bit integer divider with a registered quotient and remainder.
//  - Free-running: it continuously samples operands A and B and needs no start/done handshake.
//  - Drives a 7-segment pattern of the result for the board display.
//  - Sits between the operand switches and the display driver in the top level.
// PARAMETERS
//  - W      4  operand/quotient width (fixed at 4; listed for the package constant)
//  - RW     5  remainder register width (W+1, partial-remainder width)
// PORTS
//  - clk   in   1  system clock, rising edge
//  - rst   in   1  reset, asynchronous, active-high
//  - A     in   4  dividend, unsigned
//  - B     in   4  divisor, unsigned
//  - Q     out  4  quotient, registered
//  - R     out  5  remainder, registered; R[4] always 0 for B!=0
//  - seg   out  7  segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  - One clock; reset asynchronous active-high.
//  - Reset values: operand regs=0, Q=0, R=0, seg=pattern of hex 0 (7'b1000000).
//  - Stage 0: A and B are registered every clk into a_r and b_r (no enable).
//  - Stage 1: a 4-row combinational restoring array on a_r/b_r computes the result.
//    - Row i shifts the next dividend bit (MSB first) into the 5-bit partial remainder.
//    - It then trial-subtracts {1'b0,b_r}.
//    - If the difference is non-negative: q bit = 1 and the remainder takes the difference.
//    - Otherwise: q bit = 0 and the remainder is restored.
//  - The result is registered into Q/R on the next clk.
//  - Latency: A/B valid before edge N gives Q/R valid after edge N+1 (2 clocks).
//  - Throughput: 1 division per clock.
//  - Q/R then hold steady while A/B are steady.
//  - Invariant for B!=0: A == Q*B + R, and R < B.
//  - B==0: Q=4'hF, R={1'b0,a_r}; no exception and no hang.
//  - A<B: Q=0, R=A.  A==B (B!=0): Q=1, R=0.
//  - Operand change mid-flight: the new result appears 2 clocks after the change.
//    - No stale mixing: each output reflects one sampled A/B pair.
//  - Reset mid-operation: outputs clear immediately; the next valid result comes 2 clocks after release.
//  - seg: combinational hex decode of the registered Q (0-F), active-low.
// CONFIGURATION
//  - Macro SEG_REMAINDER_EN.
//    - Defined: seg decodes R[3:0] instead of Q.
//    - Undefined (default): seg decodes Q.
//  - Q/R behaviour is identical either way.
// STRUCTURE
//  - Package divisor_pkg: localparam W=4, RW=5; typedef logic [W-1:0] opnd_t.
//  - divisor_pkg also holds typedef logic [RW-1:0] rem_t and the 16-entry active-low 7-seg constant table.
//  - Sub-module hex_to_7seg (4-bit in, 7-bit active-low out), instantiated once.
//  - Restoring array as a generate/for loop inside divisor.
// TESTING
//  - Reset asserted mid-run: Q=0, R=0, seg=7'b1000000 asynchronously.
//  - A=8,B=2 -> within 2 clks Q=4, R=0, seg=hex4 (7'b0011001); stays stable.
//  - Sequence 9/3, 7/2, 14/4, each held 5 clks -> Q=3/R=0, Q=3/R=1, Q=3/R=2.
//  - A=5,B=5 -> Q=1, R=0.  A=3,B=7 -> Q=0, R=3.  A=15,B=1 -> Q=15, R=0.
//  - B=0, A=9 -> Q=15, R=9; then B=4 -> Q=2, R=1 after 2 clks.
//  - Exhaustive 256 pairs with B!=0, new pair each clk -> Q*B+R==A and R<B, checked 2 clks later.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared widths, operand/remainder types and the active-low 7-segment
// glyph table for the 4-bit restoring divider.
package divisor_pkg;
    localparam int W  = 4;  // operand / quotient width
    localparam int RW = 5;  // partial-remainder width (W+1)

    typedef logic [W-1:0]  opnd_t;
    typedef logic [RW-1:0] rem_t;

    // Hex glyphs, segment order {g,f,e,d,c,b,a}, active-low.
    // Entry 15 (F) is listed first, entry 0 last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };
endpackage

// File: rtl/divisor_hex_to_7seg.sv
// Combinational hex digit to active-low 7-segment pattern.
module hex_to_7seg
    import divisor_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    // Plain table lookup; all 16 entries are defined, so no default is needed.
    assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/divisor.sv
// Free-running unsigned 4-bit / 4-bit restoring divider.
// Operands are registered, divided by a combinational restoring array, and
// the quotient/remainder are registered: two clocks from operand to result.
// Optional build macro SEG_REMAINDER_EN: when defined, the 7-segment
// output shows R[3:0] instead of Q.
module divisor
    import divisor_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  A,
    input  logic [W-1:0]  B,
    output logic [W-1:0]  Q,
    output logic [RW-1:0] R,
    output logic [6:0]    seg
);
    opnd_t a_q, a_d;
    opnd_t b_q, b_d;
    opnd_t q_q, q_d;
    rem_t  r_q, r_d;

    // Restoring array: part_rem[i] is the partial remainder entering row i.
    rem_t  part_rem [0:W];
    opnd_t q_bits;

    assign part_rem[0] = '0;

    for (genvar gi = 0; gi < W; gi++) begin : g_row
        logic [RW:0] shifted;
        logic        ge;

        // Bring in the next dividend bit, MSB first.
        assign shifted = {part_rem[gi], a_q[W-1-gi]};
        // Trial subtract succeeds when the shifted remainder covers the divisor.
        // With b_q == 0 every row succeeds, giving Q = F and R = a_q.
        assign ge = (shifted >= {2'b00, b_q});
        assign q_bits[W-1-gi] = ge;
        // Keep the difference on success, otherwise restore the shifted value.
        // The partial remainder never exceeds 4 significant bits, so truncation is lossless.
        assign part_rem[gi+1] = RW'(ge ? (shifted - {2'b00, b_q}) : shifted);
    end

    // Next-state values: stage 0 samples operands, stage 1 captures the array result.
    always_comb begin
        a_d = A;
        b_d = B;
        q_d = q_bits;
        r_d = part_rem[W];
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            q_q <= '0;
            r_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            q_q <= q_d;
            r_q <= r_d;
        end
    end

    assign Q = q_q;
    assign R = r_q;

    logic [3:0] seg_src;
`ifdef SEG_REMAINDER_EN
    assign seg_src = r_q[3:0];
`else
    assign seg_src = q_q;
`endif

    hex_to_7seg u_hex_to_7seg (
        .hex (seg_src),
        .seg (seg)
    );
endmodule

// File: tb/tb_divisor.sv
// Directed bench for the 4-bit restoring divider.
module tb_divisor;
    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Q;
    logic [4:0] R;
    logic [6:0] seg;

    int errors;
    int checks;

    divisor dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Q   (Q),
        .R   (R),
        .seg (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Display glyphs expected for each directed case, chosen by which value is shown.
    localparam logic [6:0] HEX0 = 7'b1000000;
`ifdef SEG_REMAINDER_EN
    localparam logic [6:0] SEG_8_2  = 7'b1000000;  // R=0
    localparam logic [6:0] SEG_7_2  = 7'b1111001;  // R=1
    localparam logic [6:0] SEG_15_1 = 7'b1000000;  // R=0
    localparam logic [6:0] SEG_9_0  = 7'b0010000;  // R=9
`else
    localparam logic [6:0] SEG_8_2  = 7'b0011001;  // Q=4
    localparam logic [6:0] SEG_7_2  = 7'b0110000;  // Q=3
    localparam logic [6:0] SEG_15_1 = 7'b0001110;  // Q=F
    localparam logic [6:0] SEG_9_0  = 7'b0001110;  // Q=F
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b);
        A = a;
        B = b;
        $display("apply A=%0d B=%0d", a, b);
    endtask

    logic [3:0] pa [0:1];
    logic [3:0] pb [0:1];
    logic [4:0] exp_r;
    logic [3:0] exp_q;

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        A = 4'd0;
        B = 4'd0;

        // Reset state
        step(2);
        check("reset_q",   32'(Q),   32'd0);
        check("reset_r",   32'(R),   32'd0);
        check("reset_seg", 32'(seg), 32'(HEX0));
        rst = 1'b0;

        // 8/2 -> 4 r0, then held stable
        apply(4'd8, 4'd2);
        step(2);
        check("8/2_q",   32'(Q),   32'd4);
        check("8/2_r",   32'(R),   32'd0);
        check("8/2_seg", 32'(seg), 32'(SEG_8_2));
        step(3);
        check("8/2_hold_q", 32'(Q), 32'd4);
        check("8/2_hold_r", 32'(R), 32'd0);

        // Asynchronous reset in the middle of a cycle
        #2 rst = 1'b1;
        #1;
        check("async_rst_q",   32'(Q),   32'd0);
        check("async_rst_r",   32'(R),   32'd0);
        check("async_rst_seg", 32'(seg), 32'(HEX0));
        @(negedge clk);
        rst = 1'b0;
        step(2);
        check("post_rst_q", 32'(Q), 32'd4);
        check("post_rst_r", 32'(R), 32'd0);

        // Sequence held 5 clocks each
        apply(4'd9, 4'd3);
        step(5);
        check("9/3_q", 32'(Q), 32'd3);
        check("9/3_r", 32'(R), 32'd0);
        apply(4'd7, 4'd2);
        step(5);
        check("7/2_q",   32'(Q),   32'd3);
        check("7/2_r",   32'(R),   32'd1);
        check("7/2_seg", 32'(seg), 32'(SEG_7_2));
        apply(4'd14, 4'd4);
        step(5);
        check("14/4_q", 32'(Q), 32'd3);
        check("14/4_r", 32'(R), 32'd2);

        // Boundary cases
        apply(4'd5, 4'd5);
        step(2);
        check("5/5_q", 32'(Q), 32'd1);
        check("5/5_r", 32'(R), 32'd0);
        apply(4'd3, 4'd7);
        step(2);
        check("3/7_q", 32'(Q), 32'd0);
        check("3/7_r", 32'(R), 32'd3);
        apply(4'd15, 4'd1);
        step(2);
        check("15/1_q",   32'(Q),   32'd15);
        check("15/1_r",   32'(R),   32'd0);
        check("15/1_seg", 32'(seg), 32'(SEG_15_1));

        // Divide by zero, then recovery
        apply(4'd9, 4'd0);
        step(2);
        check("9/0_q",   32'(Q),   32'd15);
        check("9/0_r",   32'(R),   32'd9);
        check("9/0_seg", 32'(seg), 32'(SEG_9_0));
        apply(4'd9, 4'd4);
        step(1);
        check("9/4_midflight_q", 32'(Q), 32'd15);
        step(1);
        check("9/4_q", 32'(Q), 32'd2);
        check("9/4_r", 32'(R), 32'd1);

        // All 256 pairs, one new pair per clock, each result checked 2 clocks later.
        for (int k = 0; k < 258; k++) begin
            if (k >= 2) begin
                if (pb[0] == 4'd0) begin
                    exp_q = 4'hF;
                    exp_r = {1'b0, pa[0]};
                end else begin
                    exp_q = pa[0] / pb[0];
                    exp_r = {1'b0, pa[0] % pb[0]};
                    check("sweep_identity", 32'(Q) * 32'(pb[0]) + 32'(R), 32'(pa[0]));
                    check("sweep_r_lt_b", 32'(R < {1'b0, pb[0]}), 32'd1);
                end
                check("sweep_q", 32'(Q), 32'(exp_q));
                check("sweep_r", 32'(R), 32'(exp_r));
            end
            pa[0] = pa[1];
            pb[0] = pb[1];
            if (k < 256) begin
                pa[1] = 4'(k >> 4);
                pb[1] = 4'(k);
                A = pa[1];
                B = pb[1];
            end
            step(1);
        end
        $display("sweep of 256 operand pairs done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
